// File: rtl/mw_fifo_pkg.sv
// Shared helpers for mw_fifo: modulo-DEPTH pointer add and default field widths.
package mw_fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_PAR_WRITE  = 2;
    localparam int unsigned DEF_PAR_READ   = 3;
    localparam int unsigned DEF_DEPTH      = 5;

    localparam int unsigned DEF_CNT_W  = $clog2(DEF_DEPTH + 1);
    localparam int unsigned DEF_PTR_W  = $clog2(DEF_DEPTH);
    localparam int unsigned DEF_WCNT_W = $clog2(DEF_PAR_WRITE + 1);
    localparam int unsigned DEF_RCNT_W = $clog2(DEF_PAR_READ + 1);

    // Callers keep n <= depth, so one conditional subtract is enough.
    function automatic int unsigned ptr_add(input int unsigned ptr,
                                            input int unsigned n,
                                            input int unsigned depth);
        int unsigned s;
        s = ptr + n;
        return (s >= depth) ? (s - depth) : s;
    endfunction

endpackage

// File: rtl/mw_fifo_mem.sv
// Storage for mw_fifo: PAR_WRITE write lanes, PAR_READ asynchronous read lanes,
// lane addresses wrap modulo DEPTH.
module mw_fifo_mem
    import mw_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PAR_WRITE  = 2,
    parameter int unsigned PAR_READ   = 3,
    parameter int unsigned DEPTH      = 5
) (
    input  logic                           clk,
    input  logic [PAR_WRITE-1:0]           lane_we,
    input  logic [$clog2(DEPTH)-1:0]       wr_ptr,
    input  logic [PAR_WRITE*DATA_WIDTH-1:0] wdata,
    input  logic [$clog2(DEPTH)-1:0]       rd_ptr,
    output logic [PAR_READ*DATA_WIDTH-1:0] rdata
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]      waddr [PAR_WRITE];
    logic [DATA_WIDTH-1:0] wlane [PAR_WRITE];
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    for (genvar k = 0; k < PAR_WRITE; k++) begin : g_wlane
        assign waddr[k] = PTR_W'(ptr_add(32'(wr_ptr), k, DEPTH));
        assign wlane[k] = wdata[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Each entry owns its register; active lanes hit distinct entries, so an OR-mux suffices.
    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        logic [PAR_WRITE-1:0]  hit;
        logic [DATA_WIDTH-1:0] acc [PAR_WRITE+1];
        logic [DATA_WIDTH-1:0] q;

        assign acc[0] = '0;
        for (genvar k = 0; k < PAR_WRITE; k++) begin : g_hit
            assign hit[k]   = lane_we[k] && (waddr[k] == PTR_W'(e));
            assign acc[k+1] = acc[k] | (hit[k] ? wlane[k] : '0);
        end

        always_ff @(posedge clk) begin
            if (|hit) q <= acc[PAR_WRITE];
        end

        assign mem_q[e] = q;
    end

    for (genvar j = 0; j < PAR_READ; j++) begin : g_rlane
        logic [PTR_W-1:0] raddr;
        assign raddr = PTR_W'(ptr_add(32'(rd_ptr), j, DEPTH));
        assign rdata[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr];
    end

endmodule

// File: rtl/mw_fifo.sv
// Variable-count multi-lane circular FIFO with explicit occupancy count.
// MW_FIFO_ALMOST_FLAGS_EN builds the almost_full/almost_empty comparators.
module mw_fifo
    import mw_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned PAR_WRITE  = DEF_PAR_WRITE,
    parameter int unsigned PAR_READ   = DEF_PAR_READ,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned AF_LEVEL   = DEPTH - 1,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic                             wen,
    input  logic [$clog2(PAR_WRITE+1)-1:0]   wcnt,
    input  logic [PAR_WRITE*DATA_WIDTH-1:0]  din,
    input  logic                             ren,
    input  logic [$clog2(PAR_READ+1)-1:0]    rcnt,
    output logic [PAR_READ*DATA_WIDTH-1:0]   dout,
    output logic [$clog2(DEPTH+1)-1:0]       used_cnt,
    output logic [$clog2(DEPTH+1)-1:0]       free_cnt,
    output logic                             full,
    output logic                             empty,
    output logic                             almost_full,
    output logic                             almost_empty,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]               wr_ptr, rd_ptr;
    logic [CNT_W-1:0]               used, used_next;
    logic                           ovf_q, udf_q;
    logic                           wr_acc, rd_acc, wr_go;
    logic [PAR_WRITE-1:0]           lane_we;
    logic [PAR_READ*DATA_WIDTH-1:0] rdata;

    always_comb begin
        wr_acc    = wen && (32'(wcnt) <= 32'(free_cnt));
        rd_acc    = ren && (32'(rcnt) <= 32'(used));
        wr_go     = wr_acc && !rst && !clear;
        used_next = CNT_W'(32'(used) + (wr_acc ? 32'(wcnt) : 32'd0)
                                     - (rd_acc ? 32'(rcnt) : 32'd0));
    end

    // rst and clear produce identical register state; memory is left untouched by both.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= PTR_W'(ptr_add(32'(wr_ptr), 32'(wcnt), DEPTH));
            if (rd_acc) rd_ptr <= PTR_W'(ptr_add(32'(rd_ptr), 32'(rcnt), DEPTH));
            used <= used_next;
            if (wen && !wr_acc) ovf_q <= 1'b1;
            if (ren && !rd_acc) udf_q <= 1'b1;
        end
    end

    for (genvar k = 0; k < PAR_WRITE; k++) begin : g_we
        assign lane_we[k] = wr_go && (32'(wcnt) > 32'(k));
    end

    mw_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .PAR_WRITE  (PAR_WRITE),
        .PAR_READ   (PAR_READ),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .lane_we (lane_we),
        .wr_ptr  (wr_ptr),
        .wdata   (din),
        .rd_ptr  (rd_ptr),
        .rdata   (rdata)
    );

    for (genvar j = 0; j < PAR_READ; j++) begin : g_dout
        assign dout[j*DATA_WIDTH +: DATA_WIDTH] =
            (32'(used) > 32'(j)) ? rdata[j*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    always_comb begin
        used_cnt  = used;
        free_cnt  = CNT_W'(DEPTH) - used;
        empty     = (used == '0);
        full      = (32'(free_cnt) < PAR_WRITE);
        overflow  = ovf_q;
        underflow = udf_q;
    end

`ifdef MW_FIFO_ALMOST_FLAGS_EN
    assign almost_full  = (32'(used) >= AF_LEVEL);
    assign almost_empty = (32'(used) <= AE_LEVEL);
`else
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_mw_fifo.sv
// Self-checking bench for mw_fifo: directed vector table, hand sequences, random vs queue model.
module tb_mw_fifo;
    import mw_fifo_pkg::*;

    localparam int unsigned DW    = DEF_DATA_WIDTH;
    localparam int unsigned PW    = DEF_PAR_WRITE;
    localparam int unsigned PR    = DEF_PAR_READ;
    localparam int unsigned DEPTH = DEF_DEPTH;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1, clear = 1'b0, wen = 1'b0, ren = 1'b0;
    logic [DEF_WCNT_W-1:0]  wcnt = '0;
    logic [DEF_RCNT_W-1:0]  rcnt = '0;
    logic [PW*DW-1:0]       din = '0;
    logic [PR*DW-1:0]       dout;
    logic [DEF_CNT_W-1:0]   used_cnt, free_cnt;
    logic full, empty, almost_full, almost_empty, overflow, underflow;

    mw_fifo #(
        .DATA_WIDTH (DW),
        .PAR_WRITE  (PW),
        .PAR_READ   (PR),
        .DEPTH      (DEPTH)
    ) dut (
        .clk (clk), .rst (rst), .clear (clear),
        .wen (wen), .wcnt (wcnt), .din (din),
        .ren (ren), .rcnt (rcnt), .dout (dout),
        .used_cnt (used_cnt), .free_cnt (free_cnt),
        .full (full), .empty (empty),
        .almost_full (almost_full), .almost_empty (almost_empty),
        .overflow (overflow), .underflow (underflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        r, c, w;
        logic [1:0]  wc;
        logic [31:0] d;
        logic        rn;
        logic [1:0]  rc;
        int          used;
        logic        ovf, udf;
        logic [47:0] dout;
    } vec_t;

    function automatic vec_t mk(input logic r, c, w, input int wc, input logic [31:0] d,
                                input logic rn, input int rc, input int u,
                                input logic o, un, input logic [47:0] dt);
        vec_t v;
        v.r = r; v.c = c; v.w = w; v.wc = 2'(wc); v.d = d;
        v.rn = rn; v.rc = 2'(rc); v.used = u; v.ovf = o; v.udf = un; v.dout = dt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int u, input logic o, input logic un,
                               input logic [PR*DW-1:0] d);
        logic exp_af, exp_ae;
`ifdef MW_FIFO_ALMOST_FLAGS_EN
        exp_af = (u >= int'(DEPTH) - 1);
        exp_ae = (u <= 1);
`else
        exp_af = 1'b0;
        exp_ae = 1'b0;
`endif
        n_vec++;
        check({tag, " used_cnt"},  64'(used_cnt),  64'(u));
        check({tag, " free_cnt"},  64'(free_cnt),  64'(int'(DEPTH) - u));
        check({tag, " empty"},     64'(empty),     64'(u == 0));
        check({tag, " full"},      64'(full),      64'((int'(DEPTH) - u) < int'(PW)));
        check({tag, " overflow"},  64'(overflow),  64'(o));
        check({tag, " underflow"}, 64'(underflow), 64'(un));
        check({tag, " dout"},      64'(dout),      64'(d));
        check({tag, " almost_full"},  64'(almost_full),  64'(exp_af));
        check({tag, " almost_empty"}, 64'(almost_empty), 64'(exp_ae));
    endtask

    task automatic drive(input logic r, c, w, input logic [1:0] wc, input logic [31:0] d,
                         input logic rn, input logic [1:0] rc);
        rst = r; clear = c; wen = w; wcnt = wc; din = d; ren = rn; rcnt = rc;
        @(posedge clk);
        #1;
    endtask

    vec_t vt[$];
    logic [DW-1:0] q[$];
    logic mo, mu;

    initial begin
        vt.push_back(mk(1,0,0,0,0,                   0,0, 0,0,0, 48'h0));
        vt.push_back(mk(0,0,1,2,{16'h2,16'h1},       0,0, 2,0,0, {16'h0,16'h2,16'h1}));
        vt.push_back(mk(0,0,1,2,{16'h4,16'h3},       0,0, 4,0,0, {16'h3,16'h2,16'h1}));
        vt.push_back(mk(0,0,1,2,{16'h6,16'h5},       0,0, 4,1,0, {16'h3,16'h2,16'h1}));
        vt.push_back(mk(0,0,0,0,0,                   1,3, 1,1,0, {16'h0,16'h0,16'h4}));
        vt.push_back(mk(0,0,1,2,{16'h6,16'h5},       0,0, 3,1,0, {16'h6,16'h5,16'h4}));
        vt.push_back(mk(0,0,1,2,{16'h8,16'h7},       0,0, 5,1,0, {16'h6,16'h5,16'h4}));
        vt.push_back(mk(0,0,1,1,{16'h0,16'h9},       1,1, 4,1,0, {16'h7,16'h6,16'h5}));
        vt.push_back(mk(0,0,0,0,0,                   1,3, 1,1,0, {16'h0,16'h0,16'h8}));
        vt.push_back(mk(0,0,0,0,0,                   1,2, 1,1,1, {16'h0,16'h0,16'h8}));
        vt.push_back(mk(0,0,0,0,0,                   1,1, 0,1,1, 48'h0));
        vt.push_back(mk(0,1,1,2,{16'hb,16'ha},       0,0, 0,0,0, 48'h0));
        vt.push_back(mk(0,0,1,2,{16'h12,16'h11},     0,0, 2,0,0, {16'h0,16'h12,16'h11}));
        vt.push_back(mk(0,0,1,1,{16'h0,16'h13},      1,0, 3,0,0, {16'h13,16'h12,16'h11}));
        vt.push_back(mk(1,1,1,2,{16'h15,16'h14},     1,1, 0,0,0, 48'h0));
        vt.push_back(mk(0,0,1,0,{16'hff,16'hff},     0,0, 0,0,0, 48'h0));
        vt.push_back(mk(0,0,0,0,0,                   1,0, 0,0,0, 48'h0));
        vt.push_back(mk(0,0,0,0,0,                   1,1, 0,0,1, 48'h0));
        vt.push_back(mk(0,0,1,2,{16'h22,16'h21},     1,1, 2,0,1, {16'h0,16'h22,16'h21}));

        for (int unsigned i = 0; i < vt.size(); i++) begin
            drive(vt[i].r, vt[i].c, vt[i].w, vt[i].wc, vt[i].d, vt[i].rn, vt[i].rc);
            check_state($sformatf("vec%0d", i), vt[i].used, vt[i].ovf, vt[i].udf, vt[i].dout[PR*DW-1:0]);
        end

        // Status must not react to request inputs until the next edge.
        rst = 0; clear = 0; ren = 1; rcnt = 2; wen = 1; wcnt = 2; din = {16'h77, 16'h66};
        #2;
        check_state("no_comb_path", 2, 0, 1, {16'h0,16'h22,16'h21});

        // rst in the middle of a write burst discards that cycle's requests.
        drive(0,0,1,2,{16'h31,16'h30}, 0,0);
        check_state("burst_a", 4, 0, 1, {16'h30,16'h22,16'h21});
        drive(1,0,1,2,{16'h33,16'h32}, 1,1);
        check_state("burst_rst", 0, 0, 0, 48'h0);
        drive(0,0,1,1,{16'h0,16'h40}, 0,0);
        check_state("post_rst_wr", 1, 0, 0, {16'h0,16'h0,16'h40});

        // Repeated rejects at full: no storage, overflow stays sticky.
        drive(0,0,1,2,{16'h42,16'h41}, 0,0);
        drive(0,0,1,2,{16'h44,16'h43}, 0,0);
        check_state("fill5", 5, 0, 0, {16'h42,16'h41,16'h40});
        drive(0,0,1,1,{16'h0,16'h45}, 0,0);
        drive(0,0,1,1,{16'h0,16'h46}, 0,0);
        check_state("full_rej", 5, 1, 0, {16'h42,16'h41,16'h40});
        drive(0,1,0,0,0, 0,0);
        check_state("clear_only", 0, 0, 0, 48'h0);

        // Random traffic against a queue model.
        q.delete(); mo = 0; mu = 0;
        for (int unsigned cyc = 0; cyc < 600; cyc++) begin
            logic r, c, w, rn;
            logic [1:0] wc, rc;
            logic [31:0] d;
            logic wa, ra;
            logic [PR*DW-1:0] ed;
            r  = ($urandom_range(0, 99) == 0);
            c  = ($urandom_range(0, 49) == 0);
            w  = ($urandom_range(0, 9) < 7);
            rn = ($urandom_range(0, 9) < 6);
            wc = 2'($urandom_range(0, PW));
            rc = 2'($urandom_range(0, PR));
            d  = $urandom;
            drive(r, c, w, wc, d, rn, rc);
            if (r || c) begin
                q.delete(); mo = 0; mu = 0;
            end else begin
                wa = w  && (int'(wc) <= int'(DEPTH) - q.size());
                ra = rn && (int'(rc) <= q.size());
                if (w  && !wa) mo = 1;
                if (rn && !ra) mu = 1;
                if (ra) repeat (int'(rc)) void'(q.pop_front());
                if (wa) for (int k = 0; k < int'(wc); k++) q.push_back(d[k*DW +: DW]);
            end
            ed = '0;
            for (int k = 0; k < int'(PR); k++)
                if (k < q.size()) ed[k*DW +: DW] = q[k];
            check_state($sformatf("rnd%0d", cyc), q.size(), mo, mu, ed);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mw_fifo.md
# mw_fifo

Variable-count multi-lane circular FIFO, the next generation of the team's parallel-write/parallel-read buffer. Each cycle accepts 0..PAR_WRITE words and releases 0..PAR_READ words. Each transfer is all-or-nothing, and occupancy is tracked explicitly so all DEPTH entries are usable. It sits between the convolution datapath stages where producers and consumers emit ragged word counts, for example at row ends and padding.

## Interface
- DATA_WIDTH, 16, bits per word
- PAR_WRITE, 2, max words written per cycle
- PAR_READ, 3, max words read per cycle
- DEPTH, 5, storage words; any integer ≥ max(PAR_WRITE, PAR_READ), not required to be a power of 2
- AF_LEVEL, DEPTH-1, almost_full threshold (used ≥ AF_LEVEL)
- AE_LEVEL, 1, almost_empty threshold (used ≤ AE_LEVEL)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset; dominates every other input
- clear  in  1  synchronous flush of pointers, count and sticky flags
- wen  in  1  write request
- wcnt  in  $clog2(PAR_WRITE+1)  words offered; lane 0 is written first
- din  in  PAR_WRITE*DATA_WIDTH  write lanes; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH]
- ren  in  1  read request
- rcnt  in  $clog2(PAR_READ+1)  words to pop
- dout  out  PAR_READ*DATA_WIDTH  show-ahead window; lane 0 is the oldest word
- used_cnt  out  $clog2(DEPTH+1)  words stored
- free_cnt  out  $clog2(DEPTH+1)  equals DEPTH-used_cnt
- full  out  1  free_cnt < PAR_WRITE
- empty  out  1  used_cnt == 0
- almost_full, almost_empty  out  1 each  threshold flags
- overflow, underflow  out  1 each  sticky error flags

## Operation
- Internal state: rd_ptr and wr_ptr (range 0..DEPTH-1) plus used count.
- Pointer increments wrap modulo DEPTH: if ptr+n ≥ DEPTH, subtract DEPTH. Pointers are never masked to a bit width.
- Write acceptance: wr_acc = wen & (wcnt ≤ free_cnt). wcnt is evaluated against the pre-cycle free_cnt. Slots freed by a same-cycle read are not reusable until the next cycle.
- Accepted write: lane k is stored at (wr_ptr+k) mod DEPTH for k < wcnt; wr_ptr advances by wcnt.
- Rejected write (wen & wcnt > free_cnt): nothing is stored, pointers are unchanged, and overflow is set.
- Read acceptance: rd_acc = ren & (rcnt ≤ used_cnt); rd_ptr advances by rcnt. A rejected read sets underflow; nothing is popped.
- wcnt = 0 or rcnt = 0 with the enable high is an accepted no-op.
- Next count: used_next = used + (wr_acc ? wcnt : 0) − (rd_acc ? rcnt : 0). Simultaneous accepted read and write are both applied.
- dout lane k = mem[(rd_ptr+k) mod DEPTH] when k < used_cnt; otherwise 0. dout is combinational from registered state and changes only after a clock edge.
- overflow and underflow stay set until rst or clear.
- clear: pointers, count and sticky flags go to 0. Memory contents are not cleared. All wen/ren requests in the clear cycle are ignored.

## Timing
- Reset values: used_cnt=0, free_cnt=DEPTH, empty=1, full=(DEPTH<PAR_WRITE ? 1 : 0), which is 0 given the DEPTH constraint; almost_empty=1; almost_full=0; overflow=underflow=0; dout=0.
- Write-to-read latency is 1 cycle: a word written at edge n is visible on dout after edge n. There is no same-cycle bypass.
- All status outputs are registered state or decoded from registered state. None depends combinationally on wen, ren, wcnt or rcnt.
- rst asserted mid-burst: state returns to the reset values at that edge, and the requests in that cycle are discarded.

## Configuration
- MW_FIFO_ALMOST_FLAGS_EN defined: almost_full and almost_empty are computed from AF_LEVEL and AE_LEVEL as above.
- Not defined: the comparators are not built, and both ports are tied to 0. All other behaviour is identical.

## Structure
- Package mw_fifo_pkg holds:
  - function ptr_add(ptr, n, depth), implementing the modulo-DEPTH add;
  - width localparams for count, pointer and lane-count fields.
- Sub-module mw_fifo_mem is the storage array, with PAR_WRITE write lanes and PAR_READ asynchronous read lanes. It performs modular addressing internally.
- mw_fifo holds the pointers, count, acceptance logic and flags.

## Test plan
Default parameters (16/2/3/5) unless stated.
- **Reset:** after rst → used=0, free=5, empty=1, full=0, overflow=0, dout=0.
- **Fill and reject:** write (0x1,0x2), (0x3,0x4), then (0x5,0x6) with wcnt=2. The third write is rejected → used=4, overflow=1, dout=(0x1,0x2,0x3).
- **Wrap-around:**
  - read rcnt=3 → used=1, dout lane 0=0x4;
  - write (0x5,0x6) then (0x7,0x8) → used=5, full=1;
  - pointers wrap and dout=(0x4,0x5,0x6).
- **Simultaneous requests:** at used=5, wen wcnt=1 with ren rcnt=1 in the same cycle → write rejected, overflow=1, read accepted, used=4.
- **Short read:** at used=1, ren rcnt=2 → rejected, underflow=1, used=1, dout lanes 1–2=0. An rcnt=1 read then succeeds → empty=1.
- **Clear and reset priority:** clear with wen in the same cycle → used=0 and flags cleared. rst and clear asserted together → reset values.
